// File: rtl/encoder_16x4.sv
// -----------------------------------------------------------------------------
// encoder_16x4
//
// Active-low 16-line event encoder. Each new high-to-low transition on a
// request line d_in[15:1] is captured as a pending event and reported as a
// 4-bit opcode (the line index, 1..15) over a valid/ready handshake, lowest
// index first. Line 0 is reserved because code 0 means "all lines high" to
// the matching 4x16 decoder, so it is never encoded.
//
// Parameters:
//   SYNC_STAGES  input synchronizer depth per line (0..3, 0 = already in clk)
//
// Ports:
//   clk          rising-edge clock
//   init_l       asynchronous active-low reset
//   d_in         request lines, active low (bit 0 ignored)
//   ready_in     consumer accepts opcode_out this cycle
//   ovr_clr_in   synchronous clear of overrun_out
//   opcode_out   encoded line index of the event in the output slot
//   valid_out    output slot holds an unconsumed event
//   overrun_out  sticky flag: an event arrived on an already-pending line
//   pending_out  pending event bits for lines 15..1
// -----------------------------------------------------------------------------
module encoder_16x4 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        init_l,
    input  logic [15:0] d_in,
    input  logic        ready_in,
    input  logic        ovr_clr_in,
    output logic [3:0]  opcode_out,
    output logic        valid_out,
    output logic        overrun_out,
    output logic [14:0] pending_out
);

    // Line 0 carries no event; it is deliberately left unconnected.
    logic        w_unused_line0;
    assign w_unused_line0 = d_in[0];

    logic [15:1] w_s;        // synchronized request lines
    logic [15:1] r_prev;     // w_s as seen at the previous edge
    logic [15:1] w_fall;     // new assertions this edge
    logic [15:1] r_pending;
    logic [15:1] w_lowest;   // one-hot of lowest pending line
    logic [15:1] w_grant;    // w_lowest qualified by a free output slot
    logic [3:0]  w_grant_idx;
    logic        w_free;
    logic        w_any;
    logic        w_ovr_set;
    logic        r_valid;
    logic [3:0]  r_opcode;
    logic        r_overrun;

    // ---------------------------------------------------------------------
    // Input synchronizer. Resets to all ones so that idle-high lines do not
    // look like fresh assertions when init_l releases.
    // ---------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = d_in[15:1];
        end else begin : g_sync
            logic [15:1] r_sync [SYNC_STAGES];

            // NOTE: a flop array is reset element by element here on purpose;
            // it is a handful of synchronizer flops, not a RAM, and its reset
            // value is what defines "idle" for edge detection.
            always_ff @(posedge clk or negedge init_l) begin
                if (!init_l) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= '1;
                    end
                end else begin
                    // NOTE: non-blocking assignments make every stage sample
                    // the pre-edge value of its predecessor, forming a chain.
                    r_sync[0] <= d_in[15:1];
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Previous sample also resets high, so a line already low at release is
    // reported exactly once.
    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            r_prev <= '1;
        end else begin
            r_prev <= w_s;
        end
    end

    assign w_fall = r_prev & ~w_s;

    // ---------------------------------------------------------------------
    // Arbitration: lowest pending index wins whenever the slot is free.
    // ---------------------------------------------------------------------
    assign w_free   = ~r_valid | ready_in;
    assign w_any    = |r_pending;
    assign w_lowest = r_pending & (~r_pending + 15'd1);
    assign w_grant  = w_free ? w_lowest : '0;

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        w_grant_idx = '0;
        for (int i = 1; i <= 15; i++) begin
            if (w_lowest[i]) begin
                w_grant_idx = 4'(i);
            end
        end
    end

    // A fall on a line that stays pending is a lost duplicate. The granted
    // line is excluded: its fall re-arms it as a new event.
    assign w_ovr_set = |(w_fall & r_pending & ~w_grant);

    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            r_pending <= '0;
        end else begin
            // Set is applied after clear so it wins on the same bit.
            r_pending <= (r_pending & ~w_grant) | w_fall;
        end
    end

    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr_in) begin
            r_overrun <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Output slot: EMPTY (valid low) or FULL (valid high). Loads on a grant,
    // empties on a transfer with nothing pending, holds under backpressure.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge init_l) begin
        if (!init_l) begin
            r_valid  <= 1'b0;
            r_opcode <= '0;
        end else if (w_free) begin
            if (w_any) begin
                r_valid  <= 1'b1;
                r_opcode <= w_grant_idx;
            end else begin
                r_valid  <= 1'b0;
            end
        end
    end

    assign opcode_out  = r_opcode;
    assign valid_out   = r_valid;
    assign overrun_out = r_overrun;
    assign pending_out = r_pending;

endmodule

// File: tb/tb_encoder_16x4.sv
// -----------------------------------------------------------------------------
// tb_encoder_16x4
//
// Self-checking bench for encoder_16x4. A reference model tracks delayed
// line samples, the pending event set and the output slot; every predicted
// delivery is queued and a separate monitor pops it when the DUT completes a
// transfer. Directed scenarios add fixed-value checks on latency, priority,
// backpressure, overrun, line 0 and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_encoder_16x4;

    localparam int STAGES = 2;

    logic        clk = 1'b0;
    logic        init_l;
    logic [15:0] d_in;
    logic        ready_in;
    logic        ovr_clr_in;
    logic [3:0]  opcode_out;
    logic        valid_out;
    logic        overrun_out;
    logic [14:0] pending_out;

    encoder_16x4 #(.SYNC_STAGES(STAGES)) dut (
        .clk         (clk),
        .init_l      (init_l),
        .d_in        (d_in),
        .ready_in    (ready_in),
        .ovr_clr_in  (ovr_clr_in),
        .opcode_out  (opcode_out),
        .valid_out   (valid_out),
        .overrun_out (overrun_out),
        .pending_out (pending_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [15:1]   m_pend;
    bit          m_valid;
    bit [3:0]    m_op;
    bit          m_ovr;
    logic [15:0] samp[$];   // samp[0] = d_in at the most recent edge
    int          exp_q[$];  // predicted deliveries, in order

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_op    = '0;
        m_ovr   = 1'b0;
        samp.delete();
        for (int i = 0; i <= STAGES; i++) samp.push_back(16'hffff);
        exp_q.delete();
    endtask

    // Applied at each rising edge with the inputs present at that edge.
    task automatic model_edge();
        logic [15:0] s_now;
        logic [15:0] s_prev;
        int          g;
        int          idx;
        bit          ovr_set;
        bit          free;
        if (!init_l) begin
            model_reset();
            return;
        end
        idx    = STAGES - 1;
        s_now  = (STAGES == 0) ? d_in : samp[idx];
        s_prev = samp[STAGES];
        free   = !m_valid || ready_in;
        g      = 0;
        if (free) begin
            for (int i = 15; i >= 1; i--) if (m_pend[i]) g = i;
        end
        if (g != 0) m_pend[g] = 1'b0;
        ovr_set = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            if (s_prev[i] && !s_now[i]) begin
                if (m_pend[i]) ovr_set = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (ovr_clr_in) m_ovr = 1'b0;
        if (free) begin
            if (g != 0) begin
                m_valid = 1'b1;
                m_op    = 4'(g);
                exp_q.push_back(g);
            end else begin
                m_valid = 1'b0;
            end
        end
        samp.push_front(d_in);
        void'(samp.pop_back());
    endtask

    // One clock: update the model at the edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && init_l) begin
                check("valid_out", 32'(valid_out), 32'(m_valid));
                check("opcode_out", 32'(opcode_out), 32'(m_op));
                check("pending_out", 32'(pending_out), 32'(m_pend));
                check("overrun_out", 32'(overrun_out), 32'(m_ovr));
                if (valid_out && ready_in) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_transfer", 32'(opcode_out), 32'hffff_ffff);
                    end else begin
                        check("transfer_opcode", 32'(opcode_out), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        init_l     = 1'b0;
        d_in       = 16'hffff;
        ready_in   = 1'b1;
        ovr_clr_in = 1'b0;
        model_reset();

        // Reset and idle
        #3;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_opcode", 32'(opcode_out), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
        check("rst_pending", 32'(pending_out), 32'd0);
        ticks(2);
        init_l = 1'b1;
        mon_en = 1'b1;
        ticks(20);
        check("idle_valid", 32'(valid_out), 32'd0);

        // Single event on line 5, minimum latency of SYNC_STAGES+1
        d_in[5] = 1'b0;
        ticks(3);                         // edges k, k+1, k+2
        check("lat_early_valid", 32'(valid_out), 32'd0);
        tick();                           // edge k+3
        check("lat_valid", 32'(valid_out), 32'd1);
        check("lat_opcode", 32'(opcode_out), 32'd5);
        tick();
        check("single_once", 32'(valid_out), 32'd0);
        d_in[5] = 1'b1;
        ticks(5);

        // Priority and back-to-back delivery
        d_in[9]  = 1'b0;
        d_in[3]  = 1'b0;
        d_in[12] = 1'b0;
        ticks(3);
        tick();
        check("prio_1st", 32'({valid_out, opcode_out}), 32'h13);
        tick();
        check("prio_2nd", 32'({valid_out, opcode_out}), 32'h19);
        tick();
        check("prio_3rd", 32'({valid_out, opcode_out}), 32'h1c);
        tick();
        check("prio_done", 32'(valid_out), 32'd0);
        d_in = 16'hffff;
        ticks(4);

        // Backpressure on line 7
        ready_in = 1'b0;
        d_in[7]  = 1'b0;
        ticks(4);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 32'({valid_out, opcode_out}), 32'h17);
            tick();
        end
        ready_in = 1'b1;
        tick();
        check("bp_released", 32'(valid_out), 32'd0);
        d_in[7] = 1'b1;
        ticks(4);

        // Overrun on line 4 while the slot is blocked by line 2
        ready_in = 1'b0;
        d_in[2]  = 1'b0;
        ticks(4);
        d_in[2]  = 1'b1;
        d_in[4]  = 1'b0;
        ticks(4);
        check("ovr_pend_before", 32'(pending_out), 32'h0008);
        check("ovr_not_yet", 32'(overrun_out), 32'd0);
        d_in[4] = 1'b1;
        ticks(2);
        d_in[4] = 1'b0;
        ticks(4);
        check("ovr_set", 32'(overrun_out), 32'd1);
        check("ovr_pend_after", 32'(pending_out), 32'h0008);
        d_in[4] = 1'b1;
        ticks(3);
        ovr_clr_in = 1'b1;
        tick();
        ovr_clr_in = 1'b0;
        check("ovr_cleared", 32'(overrun_out), 32'd0);
        d_in[0] = 1'b0;
        ticks(4);
        check("line0_pending", 32'(pending_out), 32'h0008);
        check("line0_slot", 32'({valid_out, opcode_out}), 32'h12);
        d_in[0] = 1'b1;
        ticks(2);

        // Asynchronous reset mid-operation with three events pending
        d_in[6] = 1'b0;
        d_in[9] = 1'b0;
        ticks(4);
        check("pre_rst_pending", 32'(pending_out), 32'h0128);
        check("pre_rst_valid", 32'(valid_out), 32'd1);
        init_l = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_out), 32'd0);
        check("async_rst_opcode", 32'(opcode_out), 32'd0);
        check("async_rst_pending", 32'(pending_out), 32'd0);
        check("async_rst_overrun", 32'(overrun_out), 32'd0);
        model_reset();
        d_in     = 16'hffff;
        ready_in = 1'b1;
        #1;
        init_l = 1'b1;
        ticks(10);
        check("post_rst_idle", 32'(valid_out), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) d_in = d_in ^ (16'd1 << $urandom_range(15));
            ready_in   = ($urandom_range(2) != 0);
            ovr_clr_in = ($urandom_range(15) == 0);
            tick();
        end

        // Drain
        d_in       = 16'hffff;
        ready_in   = 1'b1;
        ovr_clr_in = 1'b0;
        ticks(30);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(valid_out), 32'd0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
